// File: rtl/arb_types.sv
// Shared types for the cache arbiter: FSM state, grant side, memory opcode.
// No logic of its own; zero latency.
// Backpressure: not applicable.
package arb_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

  // Side that did not win; used to hand the tie-break to the loser.
  function automatic grant_t other_side(input grant_t g);
    return (g == GRANT_I) ? GRANT_D : GRANT_I;
  endfunction

endpackage

// File: rtl/cache_arbiter_line_buf.sv
// Line buffer holding the most recent memory response line.
// Latency: loads on the cycle i_load is high, visible the next cycle.
// Backpressure: none; holds its value until the next load or reset.
module cache_arbiter_line_buf #(
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [LINE_WIDTH-1:0] i_dat,
  output logic [LINE_WIDTH-1:0] o_dat
);

  logic [LINE_WIDTH-1:0] r_line;

  // Capture the returned line; cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line <= '0;
    end else if (i_load) begin
      r_line <= i_dat;
    end
  end

  assign o_dat = r_line;

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates icache/dcache line requests onto one memory port, one transaction at a time.
// Latency: memory command 1 cycle after the IDLE request; requester resp 1 cycle after pmem_resp.
// Backpressure: losing/late requesters are simply not granted until IDLE; they must hold their request.
// Option: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking (default: dcache always wins ties).
module cache_arbiter
  import arb_types::*;
#(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  arb_state_t            r_state;
  arb_state_t            w_next_state;
  grant_t                r_gnt;
  grant_t                w_gnt;
  arb_op_t               r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic [LINE_WIDTH-1:0] w_line;
  logic                  w_i_req;
  logic                  w_d_req;
  logic                  w_grant_vld;
  logic                  w_serving;
  logic                  w_load;

  assign w_i_req     = i_read;
  assign w_d_req     = d_read | d_write;
  assign w_grant_vld = (r_state == IDLE) && (w_i_req || w_d_req);

`ifdef ARB_ROUND_ROBIN_EN
  grant_t r_rr_ptr;

  // Winner selection: a tie goes to the side the pointer favours.
  always_comb begin
    w_gnt = GRANT_D;
    if (w_i_req && w_d_req) begin
      w_gnt = r_rr_ptr;
    end else if (w_i_req) begin
      w_gnt = GRANT_I;
    end
  end

  // Every grant hands the next tie to the side that was not granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= GRANT_D;
    end else if (w_grant_vld) begin
      r_rr_ptr <= other_side(w_gnt);
    end
  end
`else
  // Winner selection: dcache wins any tie.
  always_comb begin
    w_gnt = GRANT_D;
    if (w_i_req && !w_d_req) begin
      w_gnt = GRANT_I;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and outputs; memory commands come only from latched request fields.
  always_comb begin
    w_next_state = r_state;
    w_serving    = 1'b0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_vld) begin
          w_next_state = (w_gnt == GRANT_I) ? SERVE_I : SERVE_D;
        end
      end
      SERVE_I, SERVE_D: begin
        w_serving = 1'b1;
        if (pmem_resp) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        i_resp       = (r_gnt == GRANT_I);
        d_resp       = (r_gnt == GRANT_D);
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign pmem_read    = w_serving && (r_op == OP_READ);
  assign pmem_write   = w_serving && (r_op == OP_WRITE);
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;
  assign w_load       = w_serving && pmem_resp;

  // Latch the winner's request at grant; read+write together is a write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt   <= GRANT_D;
      r_op    <= OP_READ;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant_vld) begin
      r_gnt <= w_gnt;
      if (w_gnt == GRANT_I) begin
        r_op    <= OP_READ;
        r_addr  <= i_address;
        r_wdata <= '0;
      end else begin
        r_op    <= d_write ? OP_WRITE : OP_READ;
        r_addr  <= d_address;
        r_wdata <= d_wdata;
      end
    end
  end

  cache_arbiter_line_buf #(
    .LINE_WIDTH(LINE_WIDTH)
  ) u_line_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .i_load(w_load),
    .i_dat (pmem_rdata),
    .o_dat (w_line)
  );

  assign i_rdata = w_line;
  assign d_rdata = w_line;

endmodule
